// File: rtl/ps2_pkg.sv
// Shared constants for the APB4 PS/2 receiver: CSR offsets, register bit positions
// and the frame FSM state encoding.
package ps2_pkg;

    localparam logic [7:0] CSR_CTRL = 8'h00;
    localparam logic [7:0] CSR_DATA = 8'h04;
    localparam logic [7:0] CSR_STAT = 8'h08;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_RXIE    = 1;
    localparam int unsigned CTRL_ERRIE   = 2;
    localparam int unsigned CTRL_THR_LSB = 8;

    localparam int unsigned STAT_EMPTY   = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_OVF     = 2;
    localparam int unsigned STAT_PERR    = 3;
    localparam int unsigned STAT_FERR    = 4;
    localparam int unsigned STAT_TOERR   = 5;

    typedef logic [1:0] rx_state_e;
    localparam rx_state_e IDLE   = 2'd0;
    localparam rx_state_e DATA   = 2'd1;
    localparam rx_state_e PARITY = 2'd2;
    localparam rx_state_e STOP   = 2'd3;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: input synchronisers, clock glitch filter,
// start/data/parity/stop FSM and inter-edge timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_push_o,
    output logic       rx_perr_o,
    output logic       rx_ferr_o,
    output logic       rx_toerr_o
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_s, dat_s;
    logic          filt_q;
    logic [FW-1:0] flt_cnt_q;
    logic          flt_flip, fall;

    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    // Filtered clock flips only on the FILTER_LEN-th consecutive differing sample.
    assign flt_flip = (clk_s != filt_q) && (flt_cnt_q == FW'(FILTER_LEN - 1));
    assign fall     = flt_flip & filt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            flt_cnt_q  <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            if (clk_s == filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_flip) begin
                filt_q    <= clk_s;
                flt_cnt_q <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + FW'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_ok_d   = par_ok_q;
        to_cnt_d   = to_cnt_q;
        rx_push_o  = 1'b0;
        rx_perr_o  = 1'b0;
        rx_ferr_o  = 1'b0;
        rx_toerr_o = 1'b0;
        if (!en_i) begin
            state_d  = IDLE;
            to_cnt_d = '0;
        end else if (fall) begin
            to_cnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!dat_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_ok_d = ^{shift_q, dat_s};
                    state_d  = STOP;
                end
                STOP: begin
                    if (!dat_s)          rx_ferr_o = 1'b1;
                    else if (!par_ok_q)  rx_perr_o = 1'b1;
                    else                 rx_push_o = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                rx_toerr_o = 1'b1;
                state_d    = IDLE;
                to_cnt_d   = '0;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_ok_q  <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_ok_q  <= par_ok_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign rx_byte_o = shift_q;

endmodule

// File: rtl/apb4_ps2_rx_ctrl.sv
// APB4 PS/2 receiver: frame receiver, byte FIFO, CTRL/DATA/STAT registers with
// sticky W1C error flags and a maskable registered level interrupt.
module apb4_ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 50000,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic              hclk,
    input  logic              hrst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              ps2_clk_i,
    input  logic              ps2_dat_i,
    output logic              irq_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned AW = PW - 1;

    logic          en_q, rxie_q, errie_q;
    logic [7:0]    thr_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic          ovf_q, perr_q, ferr_q, toerr_q;
    logic          irq_q;

    logic [7:0]    rx_byte;
    logic          rx_push, rx_perr, rx_ferr, rx_toerr;

    logic              access;
    logic [ADDR_W-1:0] word_addr;
    logic              sel_ctrl, sel_data, sel_stat;
    logic [PW-1:0]     level, thr_eff;
    logic              empty, full, pop, push_ok, ovf_set, w1c, wr_ctrl;
    logic [7:0]        head;
    logic              unused_bits;

    ps2_rx_frame #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_frame (
        .clk_i      (hclk),
        .rst_i      (hrst),
        .en_i       (en_q),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .rx_byte_o  (rx_byte),
        .rx_push_o  (rx_push),
        .rx_perr_o  (rx_perr),
        .rx_ferr_o  (rx_ferr),
        .rx_toerr_o (rx_toerr)
    );

    assign access    = psel & penable;
    assign word_addr = {paddr[ADDR_W-1:2], 2'b00};
    assign sel_ctrl  = (word_addr == ADDR_W'(CSR_CTRL));
    assign sel_data  = (word_addr == ADDR_W'(CSR_DATA));
    assign sel_stat  = (word_addr == ADDR_W'(CSR_STAT));

    assign level   = wr_ptr_q - rd_ptr_q;
    assign empty   = (level == '0);
    assign full    = (level == PW'(FIFO_DEPTH));
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign pop     = access & ~pwrite & sel_data & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = rx_push & (~full | pop);
    assign ovf_set = rx_push & full & ~pop;
    assign w1c     = access & pwrite & sel_stat;
    assign wr_ctrl = access & pwrite & sel_ctrl;

    assign pready  = 1'b1;
    assign pslverr = access & (~(sel_ctrl | sel_data | sel_stat) | (pwrite & sel_data));

    always_comb begin
        prdata = '0;
        if (access && !pwrite) begin
            if (sel_ctrl) begin
                prdata = {16'b0, thr_q, 5'b0, errie_q, rxie_q, en_q};
            end else if (sel_data) begin
                prdata = empty ? 32'b0 : {23'b0, 1'b1, head};
            end else if (sel_stat) begin
                prdata = {16'(level), 10'b0, toerr_q, ferr_q, perr_q, ovf_q, full, empty};
            end
        end
    end

    always_comb begin
        if (thr_q == 8'd0)                    thr_eff = PW'(1);
        else if (32'(thr_q) >= FIFO_DEPTH)    thr_eff = PW'(FIFO_DEPTH);
        else                                  thr_eff = PW'(thr_q);
    end

    always_ff @(posedge hclk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= rx_byte;
    end

    always_ff @(posedge hclk) begin
        if (hrst) begin
            en_q     <= 1'b0;
            rxie_q   <= 1'b0;
            errie_q  <= 1'b0;
            thr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            toerr_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en_q    <= pwdata[CTRL_EN];
                rxie_q  <= pwdata[CTRL_RXIE];
                errie_q <= pwdata[CTRL_ERRIE];
                thr_q   <= pwdata[CTRL_THR_LSB +: 8];
            end
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            // Set beats clear so an error coinciding with its W1C is not lost.
            ovf_q   <= (ovf_q   & ~(w1c & pwdata[STAT_OVF]))   | ovf_set;
            perr_q  <= (perr_q  & ~(w1c & pwdata[STAT_PERR]))  | rx_perr;
            ferr_q  <= (ferr_q  & ~(w1c & pwdata[STAT_FERR]))  | rx_ferr;
            toerr_q <= (toerr_q & ~(w1c & pwdata[STAT_TOERR])) | rx_toerr;
            irq_q   <= (rxie_q & (level >= thr_eff))
                     | (errie_q & (ovf_q | perr_q | ferr_q | toerr_q));
        end
    end

    assign irq_o = irq_q;

    assign unused_bits = ^{paddr[1:0], pwdata[31:16], pwdata[7:6]};

endmodule
